ds_40_sched: RTL

Round-robin scheduler that shares one `ds_40` 40 MHz serializer between `NUM_REQ` byte requesters. It accepts one byte at a time through a valid/ready handshake, pulses the serializer `enable` for one load cycle, and then holds `enable` low for exactly 8 shift cycles so the byte leaves LSB-first. An optional idle gap follows each byte. The block sits directly in front of `ds_40` and drives its `data_in` and `enable` pins.

---
 rtl/ds_40_sched_if.sv | 28 ++
 rtl/ds_40_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/ds_40_sched_if.sv
// Requester handshake and serializer-side bus of the ds_40 byte scheduler.
// The scheduler uses the slave modport; requesters and observers use master.
interface ds_40_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0]           ser_data;
  logic                 ser_enable;
  logic                 frame_start;
  logic [2:0]           bit_idx;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic [15:0]          tx_count;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_data, ser_enable, frame_start, bit_idx, grant_id, busy, tx_count
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_data, ser_enable, frame_start, bit_idx, grant_id, busy, tx_count
  );
endinterface

// File: rtl/ds_40_sched.sv
// Round-robin byte scheduler feeding one ds_40 serializer: 1 load cycle, 8 shift cycles, optional gap.
// Accepts the next byte in the last shift/gap cycle so back-to-back bytes leave with no dead cycles.
module ds_40_sched #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic          clock_40,
  input  logic          reset,
  input  logic          run,
  ds_40_sched_if.slave  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t              r_state;
  logic [2:0]          r_bit_idx;
  logic [3:0]          r_gap_cnt;
  logic [GW-1:0]       r_last_grant;
  logic [GW-1:0]       r_grant_id;
  logic [7:0]          r_ser_data;
  logic                r_ser_enable;
  logic                r_busy;
  logic [15:0]         r_tx_count;

  logic                w_open;
  logic                w_found;
  logic                w_accept;
  logic [GW-1:0]       w_gnt;
  logic [NUM_REQ-1:0]  w_ready;

  always_comb begin
    w_open = (r_state == S_IDLE) ||
             (r_state == S_SHIFT && r_bit_idx == 3'd7 && GAP_CYCLES == 0) ||
             (r_state == S_GAP && r_gap_cnt == GAP_LAST);
    w_found = 1'b0;
    w_gnt   = '0;
    w_ready = '0;
    // Search starts just after the last grant so every requester gets a turn.
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = idx[GW-1:0];
      end
    end
    w_accept = w_found & w_open & run & reset;
    if (w_accept) w_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clock_40 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_idx    <= 3'd0;
      r_gap_cnt    <= 4'd0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_ser_data   <= 8'd0;
      r_ser_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_count   <= 16'd0;
    end else begin
      r_ser_enable <= 1'b0;
      if (w_accept) begin
        r_state      <= S_LOAD;
        r_ser_data   <= bus.req_data[8*int'(w_gnt) +: 8];
        r_ser_enable <= 1'b1;
        r_grant_id   <= w_gnt;
        r_last_grant <= w_gnt;
        r_tx_count   <= r_tx_count + 16'd1;
        r_bit_idx    <= 3'd0;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: r_busy <= 1'b0;
          S_LOAD: begin
            r_state   <= S_SHIFT;
            r_bit_idx <= 3'd0;
          end
          S_SHIFT: begin
            if (r_bit_idx != 3'd7) begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
              r_bit_idx <= 3'd0;
              if (GAP_CYCLES > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= 4'd0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 4'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.ser_data    = r_ser_data;
  assign bus.ser_enable  = r_ser_enable;
  assign bus.frame_start = r_ser_enable;
  assign bus.bit_idx     = r_bit_idx;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = r_busy;
  assign bus.tx_count    = r_tx_count;
endmodule
